// File: rtl/gat_loader_pkg.sv
// gat_loader_pkg: shared types and constants for the GAT BRAM loader.
//   state_e  : loader FSM state (IDLE, LOAD, FLUSH, DONE)
//   ADDR_LSB : byte-address shift; BRAM addra = word index << ADDR_LSB
package gat_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int unsigned ADDR_LSB = 2;

endpackage

// File: rtl/gat_bram_loader_if.sv
// gat_bram_loader_if: valid/ready word stream feeding the BRAM loader.
//   s_valid : beat valid          (master -> slave)
//   s_data  : stream word         (master -> slave)
//   s_last  : final-beat marker   (master -> slave)
//   s_ready : loader accepts beat (slave -> master)
interface gat_bram_loader_if #(
  parameter int unsigned DATA_WIDTH = 19
) ();

  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_last;

  modport master (output s_valid, output s_data, output s_last, input  s_ready);
  modport slave  (input  s_valid, input  s_data, input  s_last, output s_ready);

endinterface

// File: rtl/gat_bram_wr_stage.sv
// gat_bram_wr_stage: registered BRAM write port.
//   clk, rst   : clock, asynchronous active-high reset
//   wr_en      : write this cycle (accepted beat)
//   wr_data    : word to write
//   wr_idx     : word index; presented as byte address wr_idx << ADDR_LSB
//   bram_din/ena/wea/addra : registered BRAM port; din/addra hold when idle
module gat_bram_wr_stage
  import gat_loader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 19,
  parameter int unsigned ADDR_W     = 18
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [DATA_WIDTH-1:0]      wr_data,
  input  logic [ADDR_W-1:0]          wr_idx,
  output logic [DATA_WIDTH-1:0]      bram_din,
  output logic                       bram_ena,
  output logic                       bram_wea,
  output logic [ADDR_W+ADDR_LSB-1:0] bram_addra
);

  logic [DATA_WIDTH-1:0]      din_q,  din_d;
  logic                       ena_q,  ena_d;
  logic [ADDR_W+ADDR_LSB-1:0] addr_q, addr_d;

  always_comb begin
    din_d  = din_q;
    addr_d = addr_q;
    ena_d  = wr_en;
    if (wr_en) begin
      din_d  = wr_data;
      addr_d = {wr_idx, {ADDR_LSB{1'b0}}};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      din_q  <= '0;
      ena_q  <= 1'b0;
      addr_q <= '0;
    end else begin
      din_q  <= din_d;
      ena_q  <= ena_d;
      addr_q <= addr_d;
    end
  end

  assign bram_din   = din_q;
  assign bram_ena   = ena_q;
  assign bram_wea   = ena_q;
  assign bram_addra = addr_q;

endmodule

// File: rtl/gat_bram_loader.sv
// gat_bram_loader: fills one GAT input BRAM from a valid/ready word stream.
//   clk, rst    : clock, asynchronous active-high reset
//   start       : one-cycle pulse; latches min(num_words, DEPTH), starts a load
//   num_words   : words to load this run
//   s           : stream slave (s_valid, s_ready, s_data, s_last)
//   bram_*      : byte-addressed BRAM write port (word index in addra[ADDR_W+1:2])
//   load_done   : level, memory fully written (held until next start/rst)
//   busy        : load in progress (LOAD or FLUSH)
//   err         : sticky protocol error
// Optional feature macro GAT_LOADER_CHECK_EN: enables s_last / count checking
// into err; when undefined s_last is ignored and err is tied low.
module gat_bram_loader
  import gat_loader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 19,
  parameter int unsigned DEPTH      = 242101,
  parameter int unsigned ADDR_W     = $clog2(DEPTH),
  parameter int unsigned CNT_W      = ADDR_W + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CNT_W-1:0]      num_words,
  gat_bram_loader_if.slave      s,
  output logic [DATA_WIDTH-1:0] bram_din,
  output logic                  bram_ena,
  output logic                  bram_wea,
  output logic [ADDR_W+1:0]     bram_addra,
  output logic                  load_done,
  output logic                  busy,
  output logic                  err
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic [ADDR_W-1:0] idx_q,   idx_d;
  logic [CNT_W-1:0]  clamp_cnt;
  logic              accept;
  logic              last_beat;

  assign clamp_cnt = (num_words > DEPTH_C) ? DEPTH_C : num_words;
  assign accept    = s.s_valid && (state_q == LOAD);
  // cnt >= 1 whenever LOAD is entered, so cnt-1 never underflows here.
  assign last_beat = ({1'b0, idx_q} == (cnt_q - 1'b1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          cnt_d   = clamp_cnt;
          idx_d   = '0;
          state_d = (clamp_cnt == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        // idx stops at cnt-1 so it never wraps when cnt == DEPTH.
        if (accept) begin
          if (last_beat) state_d = FLUSH;
          else           idx_d   = idx_q + 1'b1;
        end
      end
      FLUSH:   state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

`ifdef GAT_LOADER_CHECK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if ((state_q == IDLE || state_q == DONE) && start) begin
      err_d = (num_words > DEPTH_C);
    end else if (accept) begin
      if (s.s_last != last_beat) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign s.s_ready = (state_q == LOAD);
  assign busy      = (state_q == LOAD) || (state_q == FLUSH);
  assign load_done = (state_q == DONE);

  gat_bram_wr_stage #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_W     (ADDR_W)
  ) u_wr_stage (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (accept),
    .wr_data    (s.s_data),
    .wr_idx     (idx_q),
    .bram_din   (bram_din),
    .bram_ena   (bram_ena),
    .bram_wea   (bram_wea),
    .bram_addra (bram_addra)
  );

endmodule

// File: tb/tb_gat_bram_loader.sv
// tb_gat_bram_loader: randomized, self-checking bench for gat_bram_loader
// (DEPTH=8). A transaction-level model predicts every output each cycle;
// directed scenarios add literal expectations on the observed write log.
module tb_gat_bram_loader;

  localparam int DW    = 19;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int CW    = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [CW-1:0] num_words;
  logic [DW-1:0] bram_din;
  logic          bram_ena, bram_wea;
  logic [AW+1:0] bram_addra;
  logic          load_done, busy, err;

  gat_bram_loader_if #(.DATA_WIDTH(DW)) bif ();

  gat_bram_loader #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num_words  (num_words),
    .s          (bif),
    .bram_din   (bram_din),
    .bram_ena   (bram_ena),
    .bram_wea   (bram_wea),
    .bram_addra (bram_addra),
    .load_done  (load_done),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  int          m_cnt, m_idx, m_addr;
  bit          m_loading, m_flush, m_done, m_ena, m_err;
  logic [DW-1:0] m_din;

  always @(posedge clk or posedge rst) begin : model
    bit acc;
    if (rst) begin
      m_cnt = 0; m_idx = 0; m_addr = 0; m_din = '0;
      m_loading = 0; m_flush = 0; m_done = 0; m_ena = 0; m_err = 0;
    end else begin
      acc   = m_loading && bif.s_valid;
      m_ena = acc;
      if (acc) begin
        m_din  = bif.s_data;
        m_addr = m_idx * 4;
      end
      if (m_flush) begin
        m_flush = 0;
        m_done  = 1;
      end else if (m_loading) begin
        if (acc) begin
`ifdef GAT_LOADER_CHECK_EN
          if (bif.s_last && m_idx != m_cnt - 1) m_err = 1;
          if (!bif.s_last && m_idx == m_cnt - 1) m_err = 1;
`endif
          m_idx++;
          if (m_idx == m_cnt) begin
            m_loading = 0;
            m_flush   = 1;
          end
        end
      end else if (start) begin
        m_cnt = (int'(num_words) > DEPTH) ? DEPTH : int'(num_words);
        m_idx = 0;
        m_done = (m_cnt == 0);
        m_loading = (m_cnt != 0);
`ifdef GAT_LOADER_CHECK_EN
        m_err = (int'(num_words) > DEPTH);
`else
        m_err = 0;
`endif
      end
    end
  end

  // ---------------- compare + write log ----------------
  logic [DW-1:0] log_d[$];
  int            log_a[$];
  bit            ready_seen;

  always @(negedge clk) begin
    if (!rst) begin
      chk("s_ready",    bif.s_ready, m_loading);
      chk("busy",       busy,        m_loading || m_flush);
      chk("load_done",  load_done,   m_done);
      chk("bram_ena",   bram_ena,    m_ena);
      chk("bram_wea",   bram_wea,    m_ena);
      chk("bram_din",   bram_din,    m_din);
      chk("bram_addra", bram_addra,  m_addr);
      chk("err",        err,         m_err);
      if (bram_ena) begin
        log_d.push_back(bram_din);
        log_a.push_back(int'(bram_addra));
      end
      if (bif.s_ready) ready_seen = 1;
    end
  end

  // ---------------- stimulus ----------------
  logic [DW-1:0] next_data;
  bit            pat [5];

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_log();
    log_d.delete();
    log_a.delete();
    ready_seen = 0;
  endtask

  // mode 0: valid always; mode 1: pattern pat[] on LOAD cycles; mode 2: random pct
  task automatic run_load(input int n, input int mode, input int pct,
                          input int last_pos, input bit rand_start, output int edges);
    bit v, acc;
    int beats;
    edges = 0;
    beats = 0;
    start = 1'b1;
    num_words = CW'(n);
    for (int c = 0; c < 300; c++) begin
      if (c == 0)         v = (mode == 0);
      else if (mode == 0) v = 1;
      else if (mode == 1) v = (c - 1 < 5) ? pat[c-1] : 1'b1;
      else                v = ($urandom_range(99) < pct);
      if (c > 0) begin
        start     = rand_start && ($urandom_range(3) == 0);
        num_words = CW'($urandom_range(15));
      end
      bif.s_valid = v;
      bif.s_data  = v ? next_data : DW'($urandom);
      bif.s_last  = v && (beats == last_pos);
      acc = v && bif.s_ready;
      tick();
      edges++;
      if (acc) begin
        beats++;
        next_data = next_data + 1'b1;
      end
      if (load_done) break;
    end
    start = 1'b0;
    bif.s_valid = 1'b0;
    bif.s_last  = 1'b0;
    if (!load_done) chk("load_timeout", 0, 1);
  endtask

  localparam bit EXP_ERR_ON = `ifdef GAT_LOADER_CHECK_EN 1'b1 `else 1'b0 `endif;

  initial begin
    int edges, n, lp;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    rst = 1'b1;
    start = 1'b0;
    num_words = '0;
    bif.s_valid = 1'b0;
    bif.s_data  = '0;
    bif.s_last  = 1'b0;
    #1;
    chk("rst_ready", bif.s_ready, 0);
    chk("rst_ena",   bram_ena,    0);
    chk("rst_done",  load_done,   0);
    chk("rst_busy",  busy,        0);
    chk("rst_din",   bram_din,    0);
    chk("rst_addr",  bram_addra,  0);
    chk("rst_err",   err,         0);
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // basic load: 4 words 0xA..0xD
    clear_log();
    next_data = DW'('hA);
    run_load(4, 0, 100, 3, 0, edges);
    chk("basic_latency", edges, 6);
    chk("basic_nwrites", log_a.size(), 4);
    for (int i = 0; i < 4 && i < log_a.size(); i++) begin
      chk("basic_addr", log_a[i], 4 * i);
      chk("basic_data", log_d[i], 'hA + i);
    end
    chk("basic_ready_low", bif.s_ready, 0);
    tick();

    // backpressure: valid 1,0,0,1,1
    clear_log();
    next_data = DW'('h100);
    run_load(3, 1, 100, 2, 0, edges);
    chk("bp_nwrites", log_a.size(), 3);
    for (int i = 0; i < 3 && i < log_a.size(); i++) begin
      chk("bp_addr", log_a[i], 4 * i);
      chk("bp_data", log_d[i], 'h100 + i);
    end
    tick();

    // zero count
    clear_log();
    run_load(0, 0, 100, -1, 0, edges);
    chk("zero_latency", edges, 1);
    chk("zero_nwrites", log_a.size(), 0);
    chk("zero_ready",   ready_seen, 0);
    tick();

    // clamp 12 -> 8
    clear_log();
    next_data = DW'('h200);
    run_load(12, 0, 100, 7, 0, edges);
    chk("clamp_nwrites", log_a.size(), 8);
    if (log_a.size() > 0) chk("clamp_last_addr", log_a[log_a.size()-1], 28);
    chk("clamp_err", err, EXP_ERR_ON);
    tick();

    // early s_last on 2nd beat
    clear_log();
    next_data = DW'('h300);
    run_load(4, 0, 100, 1, 0, edges);
    chk("last_nwrites", log_a.size(), 4);
    chk("last_err", err, EXP_ERR_ON);
    tick();

    // reset mid-load after 2 of 5 beats
    clear_log();
    next_data = DW'('h400);
    start = 1'b1;
    num_words = CW'(5);
    bif.s_valid = 1'b1;
    bif.s_data  = next_data;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bif.s_data = next_data;
      tick();
      next_data = next_data + 1'b1;
    end
    bif.s_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", bif.s_ready, 0);
    chk("mid_rst_ena",   bram_ena,    0);
    chk("mid_rst_wea",   bram_wea,    0);
    chk("mid_rst_din",   bram_din,    0);
    chk("mid_rst_addr",  bram_addra,  0);
    chk("mid_rst_done",  load_done,   0);
    chk("mid_rst_busy",  busy,        0);
    chk("mid_rst_err",   err,         0);
    tick();
    rst = 1'b0;
    tick();
    clear_log();
    next_data = DW'('h500);
    run_load(2, 0, 100, 1, 0, edges);
    chk("rerun_nwrites", log_a.size(), 2);
    for (int i = 0; i < 2 && i < log_a.size(); i++) begin
      chk("rerun_addr", log_a[i], 4 * i);
      chk("rerun_data", log_d[i], 'h500 + i);
    end

    // randomized loads
    for (int it = 0; it < 40; it++) begin
      n  = $urandom_range(12);
      lp = ($urandom_range(3) != 0) ? ((n > DEPTH ? DEPTH : n) - 1) : $urandom_range(7);
      next_data = DW'($urandom);
      run_load(n, 2, 40 + $urandom_range(60), lp, 1, edges);
      repeat ($urandom_range(2)) tick();
    end

    tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/gat_bram_loader.md
# gat_bram_loader

Stream-to-BRAM loader that fills one of the GAT accelerator's input memories (H data, H node info, or weights) from a valid/ready word stream. It drives the byte-addressed BRAM write port (`*_bram_din/ena/wea/addra`, word index in `addra[ADDR_W+1:2]`) and the matching `*_load_done` level into the register bank. It sits directly upstream of the accelerator top wrapper; one instance is used per input memory.

## Interface
- `DATA_WIDTH`, 19: stream/BRAM word width (H data = value + column index).
- `DEPTH`, 242101: BRAM depth in words.
- `ADDR_W`, `$clog2(DEPTH)`: word-address width.
- `CNT_W`, `ADDR_W+1`: width of the word count.

Ports:
- `clk`  in  1  clock; all logic rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse; latches `num_words`, begins a load.
- `num_words`  in  CNT_W  words to load this run.
- `s_valid`  in  1  stream beat valid.
- `s_ready`  out  1  loader accepts a beat.
- `s_data`  in  DATA_WIDTH  stream word.
- `s_last`  in  1  marks the final beat (checked only with `GAT_LOADER_CHECK_EN`).
- `bram_din`  out  DATA_WIDTH  write data.
- `bram_ena`  out  1  BRAM enable.
- `bram_wea`  out  1  BRAM write enable.
- `bram_addra`  out  ADDR_W+2  byte address = word index << 2.
- `load_done`  out  1  level; memory fully written.
- `busy`  out  1  load in progress.
- `err`  out  1  sticky protocol error.

## Operation
- FSM states: IDLE, LOAD, FLUSH, DONE.
- IDLE or DONE with `start`=1: latch `cnt = min(num_words, DEPTH)`, clear the word index and `err`, and drop `load_done`. Next state is LOAD, or DONE directly if `cnt`=0.
- `start` is ignored in LOAD and FLUSH.
- LOAD: `s_ready`=1. A beat is accepted when `s_valid & s_ready`. Each accepted beat registers `bram_din=s_data`, `bram_ena=bram_wea=1`, `bram_addra={idx,2'b00}`, then increments `idx`.
- When the accepted beat has `idx == cnt-1`: the state moves to FLUSH on the same edge, so `s_ready` falls with no extra beat taken.
- FLUSH: the last write is on the port. Next state is DONE.
- DONE: `load_done`=1 and is held until the next `start` or `rst`.
- Cycles with no accepted beat: `bram_ena=bram_wea=0`. `bram_din` and `bram_addra` hold their last values.
- `busy` = state is LOAD or FLUSH.
- Arithmetic: `idx` is ADDR_W bits and never wraps, because `cnt ≤ DEPTH`. Address low 2 bits are always 0.
- Reset mid-load: returns to IDLE immediately. A partial BRAM content is left as-is and `load_done` stays 0.

## Timing
- Reset values: `s_ready=0`, `bram_din=0`, `bram_ena=0`, `bram_wea=0`, `bram_addra=0`, `load_done=0`, `busy=0`, `err=0`.
- `s_ready` decodes directly from the state register (no input-to-output combinational path).
- Write latency: a beat accepted at edge E appears on the BRAM port during the cycle after E.
- Throughput: 1 word/cycle. Backpressure comes only from `s_valid`.
- `start` at edge S gives LOAD, with `s_ready=1`, in the cycle after S.
- Last beat accepted at edge E: FLUSH after E, DONE after E+1.
- `load_done` therefore rises one cycle after the final BRAM write is presented.
- Total time for N words with continuous valid: N+2 cycles from `start` to `load_done`.

## Configuration
- `GAT_LOADER_CHECK_EN` defined:
  - `err` is set if an accepted beat has `s_last=1` and `idx != cnt-1`.
  - `err` is set if the final beat arrives with `s_last=0`.
  - `err` is set if `num_words > DEPTH` at `start`.
  - `err` clears only on `start` or `rst`. Data is still written; the error does not alter the load flow.
- Undefined: `s_last` is ignored and `err` is tied to 0.

## Structure
- Shared package `gat_loader_pkg`: the state enum (IDLE/LOAD/FLUSH/DONE) and the `ADDR_LSB=2` byte-address shift constant.
- The BRAM write register stage is a natural sub-module: `gat_bram_wr_stage` (registers din/ena/wea/addr with reset).

## Test plan
- Basic load: `DEPTH=8`, `num_words=4`, continuous valid, data 0xA..0xD → writes at addra 0, 4, 8, 12 with those data on consecutive cycles; `load_done=1` at cycle 6 after `start`; `s_ready` low after the 4th beat.
- Backpressure: `num_words=3`, `s_valid` pattern 1,0,0,1,1 → exactly 3 writes; `bram_ena` low in the gap cycles; addresses 0, 4, 8.
- Zero count: `num_words=0` → DONE the next cycle; no BRAM write; `s_ready` never 1.
- Clamp: `DEPTH=8`, `num_words=12` → 8 writes (last addra=28), then `load_done`; with `GAT_LOADER_CHECK_EN`, `err=1`.
- Last check (macro on): `num_words=4`, `s_last` on the 2nd beat → `err=1` after that edge; all 4 writes still occur.
- Reset mid-load: assert `rst` after 2 of 5 beats → all outputs at reset values immediately. A new `start` with `num_words=2` rewrites addra 0, 4.
